// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and sizing helpers for the sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // Down-counter width: holds WIDTH-1, the number of remaining multiplier bits after the first.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mul_abs_neg.sv
// mul_abs_neg: conditional two's complement, used for operand magnitudes and result sign fix-up.
module mul_abs_neg #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_neg ? (~i_x) + WIDTH'(1) : i_x;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per clock, signed via magnitude and final negate.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = cnt_w(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_res;

    mul_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .i_x  (a),
        .i_neg(signed_mode & a[WIDTH-1]),
        .o_y  (w_abs_a)
    );

    mul_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .i_x  (b),
        .i_neg(signed_mode & b[WIDTH-1]),
        .o_y  (w_abs_b)
    );

    mul_abs_neg #(.WIDTH(2*WIDTH)) u_fix (
        .i_x  (r_acc),
        .i_neg(r_neg),
        .o_y  (w_res)
    );

    // Upper half plus addend keeps its carry in bit WIDTH, which the right shift folds back in.
    assign w_addend = r_mag_b[0] ? {1'b0, r_mag_a} : '0;
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mag_a <= w_abs_a;
                        r_mag_b <= w_abs_b;
                        r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc   <= '0;
                        r_count <= CW'(WIDTH - 1);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mag_b <= r_mag_b >> 1;
                    r_count <= r_count - CW'(1);
                    r_state <= (r_count == '0) ? FIX : CALC;
                end
                FIX: begin
                    r_lo    <= w_res[WIDTH-1:0];
                    r_hi    <= w_res[2*WIDTH-1:WIDTH];
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign lo   = r_lo;
    assign hi   = r_hi;

endmodule
